drisc_bus_bridge: RTL

Memory-side bus bridge directly downstream of the drisc core's pad interface. Latches the address strobed by the core, turns each read/write pad strobe into a single word-aligned, byte-enabled request to a ready/handshake memory, and holds the core until the memory completes or a timeout fires. Read data returns to the core's data input through a registered buffer. Misaligned accesses and timeouts are flagged on a sticky error output.

---
 rtl/drisc_bus_bridge.sv | 127 ++++++++++++
 1 files changed

// File: rtl/drisc_bus_bridge.sv
// Bridges drisc core pad strobes to a ready/handshake memory: one word-aligned, byte-enabled request per strobe.
// Latency: 2 cycles with a zero-wait memory, +1 per wait cycle. The core is held via core_hold until completion or timeout.
module drisc_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] core_address,
    input  logic        core_write_address,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [1:0]  core_data_size,
    input  logic [31:0] core_data_out,
    input  logic        core_data_out_enable,
    output logic [31:0] core_data_in,
    output logic        core_hold,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_write_data,
    output logic        mem_request,
    output logic        mem_write_enable,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    output logic        bus_error,
    output logic        busy
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [31:0]   addr_q;
    logic [CW-1:0] wait_cnt;
    logic          legal;
    logic [3:0]    lanes;
    logic          start;
    logic          timed_out;
    logic          err_set;
    logic          unused_data_enable;

    // Stores go out with core_data_out as-is, whether or not the core is driving it.
    assign unused_data_enable = core_data_out_enable;

    always_comb begin
        legal = 1'b0;
        lanes = 4'b0000;
        case (core_data_size)
            2'b00: begin
                legal = 1'b1;
                lanes = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                legal = ~addr_q[0];
                lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal = (addr_q[1:0] == 2'b00);
                lanes = 4'b1111;
            end
            default: ;
        endcase
    end

    assign start     = (state == IDLE) && (core_read || core_write);
    // Fires on the TIMEOUT_CYCLES-th un-ready cycle; a ready in that same cycle takes priority.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !mem_ready &&
                       (({1'b0, wait_cnt} + 1'b1) == LIMIT);
    assign err_set   = (start && !legal) || timed_out;

    assign core_hold   = (state == ACCESS) || ((state == IDLE) && (core_read || core_write));
    assign mem_request = (state == ACCESS);
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            addr_q           <= '0;
            wait_cnt         <= '0;
            core_data_in     <= '0;
            mem_address      <= '0;
            mem_byte_enable  <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            bus_error        <= 1'b0;
        end else begin
            if (core_write_address)
                addr_q <= core_address;

            if (err_set)
                bus_error <= 1'b1;
            else if (core_write_address)
                bus_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            mem_address      <= {addr_q[31:2], 2'b00};
                            mem_byte_enable  <= lanes;
                            mem_write_data   <= core_data_out;
                            mem_write_enable <= core_write;
                            wait_cnt         <= '0;
                            state            <= ACCESS;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_write_enable)
                            core_data_in <= mem_read_data;
                        state <= DONE;
                    end else if (timed_out) begin
                        core_data_in <= '0;
                        state        <= DONE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
